// File: rtl/ssd_scroll_scanner.sv
// ssd_scroll_scanner: 4-digit scroll buffer multiplexed onto a common-anode 7-seg display
// Optional digit-0 blink when SSD_BLINK_EN is defined.
module ssd_scroll_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter logic [7:0] BLANK = 8'hFF,
  parameter int BLINK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       load,
  input  logic       clr,
  output logic [7:0] segs,
  output logic [3:0] ssd_ctl,
  output logic       full
);
  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  logic [7:0] sbuf [4];
  logic [2:0] cnt;
  logic [DW-1:0] div;
  logic [1:0] idx;
  logic [7:0] disp;
  logic div_wrap;
  assign div_wrap = (div == DW'(REFRESH_DIV - 1));
`ifdef SSD_BLINK_EN
  localparam int FW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0] fcnt;
  logic blink_ph;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fcnt <= '0;
      blink_ph <= 1'b0;
    end else if (div_wrap && idx == 2'd3) begin
      fcnt <= (fcnt == FW'(BLINK_DIV - 1)) ? '0 : fcnt + FW'(1);
      blink_ph <= (fcnt == FW'(BLINK_DIV - 1)) ? ~blink_ph : blink_ph;
    end
  end
  always_comb disp = (blink_ph && cnt != 3'd0 && idx == 2'd0) ? BLANK : sbuf[idx];
`else
  always_comb disp = sbuf[idx];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sbuf[i] <= BLANK;
      cnt <= '0;
      full <= 1'b0;
      div <= '0;
      idx <= '0;
      segs <= BLANK;
      ssd_ctl <= 4'b1111;
    end else begin
      if (clr) begin
        for (int i = 0; i < 4; i++) sbuf[i] <= BLANK;
        cnt <= '0;
        full <= 1'b0;
      end else if (load) begin
        sbuf[3] <= sbuf[2];
        sbuf[2] <= sbuf[1];
        sbuf[1] <= sbuf[0];
        sbuf[0] <= seg_in;
        cnt <= (cnt == 3'd4) ? cnt : cnt + 3'd1;
        full <= (cnt >= 3'd3);
      end
      div <= div_wrap ? '0 : div + DW'(1);
      idx <= div_wrap ? idx + 2'd1 : idx;
      segs <= disp;
      ssd_ctl <= ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_ssd_scroll_scanner.sv
// tb_ssd_scroll_scanner: randomized scoreboard bench against a queue-based display model
module tb_ssd_scroll_scanner;
  localparam int R = 4;
  localparam int BD = 2;
  logic clk = 0, rst = 1, load = 0, clr = 0;
  logic [7:0] seg_in = 0, segs;
  logic [3:0] ssd_ctl;
  logic full;
  typedef struct packed {logic [7:0] segs; logic [3:0] ctl; logic full;} exp_t;
  exp_t exq[$];
  logic [7:0] mq[$];
  int n = 0, wraps = 0, checks = 0, errs = 0;

  ssd_scroll_scanner #(.REFRESH_DIV(R), .BLANK(8'hFF), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .load(load), .clr(clr),
    .segs(segs), .ssd_ctl(ssd_ctl), .full(full));

  always #5 clk = ~clk;

  function automatic int cur_idx();
    return (n / R) % 4;
  endfunction

  task automatic step(input bit r, input bit l, input bit c, input logic [7:0] s);
    exp_t e;
    int d;
    rst = r; load = l; clr = c; seg_in = s;
    if (r) begin
      e.segs = 8'hFF; e.ctl = 4'b1111; e.full = 1'b0;
      mq.delete(); n = 0; wraps = 0;
    end else begin
      d = cur_idx();
      e.segs = (d < mq.size()) ? mq[d] : 8'hFF;
`ifdef SSD_BLINK_EN
      if (((wraps / BD) % 2) == 1 && mq.size() != 0 && d == 0) e.segs = 8'hFF;
`endif
      e.ctl = 4'b1111;
      e.ctl[d] = 1'b0;
      if (c) begin
        mq.delete(); wraps = 0;
      end else begin
        if (l) begin
          mq.push_front(s);
          if (mq.size() > 4) void'(mq.pop_back());
        end
        if ((n + 1) % (4 * R) == 0) wraps++;
      end
      e.full = (mq.size() == 4);
      n++;
    end
    @(posedge clk);
    exq.push_back(e);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 8'h00);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      checks += 3;
      if (segs !== e.segs) begin
        errs++;
        $display("FAIL segs t=%0t got %h expected %h", $time, segs, e.segs);
      end
      if (ssd_ctl !== e.ctl) begin
        errs++;
        $display("FAIL ssd_ctl t=%0t got %b expected %b", $time, ssd_ctl, e.ctl);
      end
      if (full !== e.full) begin
        errs++;
        $display("FAIL full t=%0t got %b expected %b", $time, full, e.full);
      end
    end
  end

  initial begin
    logic [7:0] pats [5] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
    int guard;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00);
    idle(20);
    foreach (pats[i]) begin
      step(0, 1, 0, pats[i]);
      idle($urandom_range(0, 3));
    end
    idle(20);
    step(0, 1, 1, 8'h92);
    idle(16);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'($urandom));
    guard = 0;
    while (!(cur_idx() == 2 && n % R == 1) && guard < 100) begin
      idle(1); guard++;
    end
    step(1, 1, 0, 8'h55);
    idle(16);
    guard = 0;
    while (!(cur_idx() == 0 && n % R == 0) && guard < 100) begin
      idle(1); guard++;
    end
    step(0, 1, 0, 8'h82);
    idle(70);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, 8'($urandom));
    idle(2);
    guard = 0;
    while (exq.size() > 0 && guard < 10) begin
      @(negedge clk); guard++;
    end
    if (exq.size() > 0) begin
      checks++; errs++;
      $display("FAIL drain pending %0d expected 0", exq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
